// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table tester.
// FSM state encoding, vector-count and mismatch-count width functions.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    REPORT
  } tt_state_e;

  // Number of input vectors for an n-input DUT.
  function automatic int nvec(input int n);
    return 1 << n;
  endfunction

  // Mismatch counter must hold nvec(n) itself.
  function automatic int cnt_w(input int n);
    return n + 1;
  endfunction

endpackage

// File: rtl/tt_vec_gen.sv
// Vector and settle counters for the truth-table tester.
// Ports: CLK, RST_N, i_clr, i_apply, i_step -> o_vec, o_sample, o_last.
module tt_vec_gen
  import tt_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            i_clr,
  input  logic            i_apply,
  input  logic            i_step,
  output logic [N_IN-1:0] o_vec,
  output logic            o_sample,
  output logic            o_last
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VMAX = N_IN'(nvec(N_IN) - 1);

  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_vec;

  assign o_vec    = r_vec;
  assign o_sample = i_apply && (r_cnt == CMAX);
  assign o_last   = (r_vec == VMAX);

  // Vector returns to 0 after the last sample so the
  // DUT sees 0 whenever no run is active.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
      r_vec <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_vec <= '0;
    end else if (i_step) begin
      r_cnt <= '0;
      r_vec <= o_last ? '0 : r_vec + 1'b1;
    end else if (i_apply && !o_sample) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_tester.sv
// Sweeps all inputs of a small combinational DUT and checks it
// against EXP_TABLE. Ports: CLK, RST_N, START, DUT_X -> DUT_IN,
// BUSY, DONE, PASS, FAIL_CNT, FIRST_FAIL, ERR_MAP (TT_ERRMAP_EN).
module truth_table_tester
  import tt_pkg::*;
#(
  parameter int                     N_IN      = 3,
  parameter logic [nvec(N_IN)-1:0]  EXP_TABLE = 8'hFA,
  parameter int                     SETTLE    = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     START,
  input  logic                     DUT_X,
  output logic [N_IN-1:0]          DUT_IN,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     PASS,
  output logic [cnt_w(N_IN)-1:0]   FAIL_CNT,
  output logic [N_IN-1:0]          FIRST_FAIL
`ifdef TT_ERRMAP_EN
  ,
  output logic [nvec(N_IN)-1:0]    ERR_MAP
`endif
);

  localparam int FW = cnt_w(N_IN);

  tt_state_e       r_state;
  tt_state_e       w_next;
  logic            w_go;
  logic [N_IN-1:0] w_vec;
  logic            w_smp;
  logic            w_last;
  logic            w_exp;
  logic            w_mis;
  logic [FW-1:0]   w_fcnt_nxt;
  logic            w_busy_d;
  logic            w_done_d;

  assign w_go = (r_state == IDLE) && START;

  tt_vec_gen #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_vec_gen (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .i_clr    (w_go),
    .i_apply  (r_state == APPLY),
    .i_step   (r_state == SAMPLE),
    .o_vec    (w_vec),
    .o_sample (w_smp),
    .o_last   (w_last)
  );

  // w_vec is a register inside tt_vec_gen.
  assign DUT_IN = w_vec;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (START) w_next = APPLY;
      APPLY:   if (w_smp) w_next = SAMPLE;
      SAMPLE:  w_next = w_last ? REPORT : APPLY;
      REPORT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy_d = (w_next == APPLY) || (w_next == SAMPLE);
    w_done_d = (w_next == REPORT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      BUSY <= w_busy_d;
      DONE <= w_done_d;
    end
  end

  // Case-inequality so X/Z on DUT_X counts as a mismatch in sim.
  assign w_exp = EXP_TABLE[w_vec];
  assign w_mis = (r_state == SAMPLE) && (DUT_X !== w_exp);
  assign w_fcnt_nxt = w_mis ? FAIL_CNT + 1'b1 : FAIL_CNT;

  // PASS is resolved on the last sample so it is valid with DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PASS       <= 1'b0;
      FAIL_CNT   <= '0;
      FIRST_FAIL <= '0;
    end else if (w_go) begin
      PASS       <= 1'b0;
      FAIL_CNT   <= '0;
      FIRST_FAIL <= '0;
    end else if (r_state == SAMPLE) begin
      FAIL_CNT <= w_fcnt_nxt;
      if (w_mis && (FAIL_CNT == '0)) FIRST_FAIL <= w_vec;
      if (w_last) PASS <= (w_fcnt_nxt == '0);
    end
  end

`ifdef TT_ERRMAP_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     ERR_MAP <= '0;
    else if (w_go)  ERR_MAP <= '0;
    else if (w_mis) ERR_MAP[w_vec] <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_truth_table_tester.sv
// Scoreboard bench for truth_table_tester (SETTLE=2 and SETTLE=1).
// Expected results are queued at START and checked at DONE.
`timescale 1ns/1ps
module tb_truth_table_tester;

  typedef struct {
    int   lat;
    logic pass;
    int   fcnt;
    int   ffail;
    int   emap;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       START1 = 1'b0;
  logic       X0;
  logic       X1;
  logic [2:0] DIN0, DIN1;
  logic       BUSY0, BUSY1, DONE0, DONE1, PASS0, PASS1;
  logic [3:0] FC0, FC1;
  logic [2:0] FF0, FF1;
`ifdef TT_ERRMAP_EN
  logic [7:0] EM0, EM1;
`endif

  int   mode = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  // 0: golden A|C, 1: stuck at 0, 2: stuck at 1
  always_comb begin
    X0 = 1'b0;
    if (mode == 2)      X0 = 1'b1;
    else if (mode == 0) X0 = DIN0[2] | DIN0[0];
  end
  assign X1 = 1'b1;

  truth_table_tester #(
    .N_IN(3), .EXP_TABLE(8'hFA), .SETTLE(2)
  ) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .DUT_X(X0),
    .DUT_IN(DIN0), .BUSY(BUSY0), .DONE(DONE0), .PASS(PASS0),
    .FAIL_CNT(FC0), .FIRST_FAIL(FF0)
`ifdef TT_ERRMAP_EN
    , .ERR_MAP(EM0)
`endif
  );

  truth_table_tester #(
    .N_IN(3), .EXP_TABLE(8'hFA), .SETTLE(1)
  ) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(START1), .DUT_X(X1),
    .DUT_IN(DIN1), .BUSY(BUSY1), .DONE(DONE1), .PASS(PASS1),
    .FAIL_CNT(FC1), .FIRST_FAIL(FF1)
`ifdef TT_ERRMAP_EN
    , .ERR_MAP(EM1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int m, input int settle);
    exp_t e;
    int   x;
    logic [7:0] tbl;
    tbl = 8'hFA;
    e.lat = 1 + 8 * (settle + 1);
    e.fcnt = 0;
    e.ffail = 0;
    e.emap = 0;
    for (int v = 0; v < 8; v++) begin
      if (m == 1)      x = 0;
      else if (m == 2) x = 1;
      else             x = ((v >> 2) | v) & 1;
      if (x != int'(tbl[v])) begin
        if (e.fcnt == 0) e.ffail = v;
        e.fcnt++;
        e.emap |= (1 << v);
      end
    end
    e.pass = (e.fcnt == 0);
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start0();
    START = 1'b1;
    sb.push_back(model(mode, 2));
    tick();
    START = 1'b0;
  endtask

  // Entered in the first cycle after the START edge (n=1).
  task automatic follow0(input int pulse_at, input bit walk);
    exp_t e;
    int   n;
    n = 1;
    while (DONE0 !== 1'b1 && n < 100) begin
      if (walk) begin
        check("dut_in", DIN0, (n - 1) / 3);
        check("busy", BUSY0, 1);
      end
      if (pulse_at > 0) START = (n == pulse_at);
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("latency", n, e.lat);
      check("pass", PASS0, e.pass);
      check("fail_cnt", FC0, e.fcnt);
      check("first_fail", FF0, e.ffail);
`ifdef TT_ERRMAP_EN
      check("err_map", EM0, e.emap);
`endif
      check("busy_rpt", BUSY0, 0);
      check("dut_in_rpt", DIN0, 0);
    end
    tick();
    check("done_pulse", DONE0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_din"}, DIN0, 0);
    check({tag, "_busy"}, BUSY0, 0);
    check({tag, "_done"}, DONE0, 0);
    check({tag, "_pass"}, PASS0, 0);
    check({tag, "_fcnt"}, FC0, 0);
    check({tag, "_ffail"}, FF0, 0);
`ifdef TT_ERRMAP_EN
    check({tag, "_emap"}, EM0, 0);
`endif
  endtask

  initial begin
    exp_t e;
    int   n;

    // reset with START toggling
    for (int i = 0; i < 4; i++) begin
      START = i[0];
      tick();
      check_zero("rst");
    end
    START = 1'b0;
    RST_N = 1'b1;
    tick();
    check_zero("idle");

    // golden run, full walk
    mode = 0;
    start0();
    follow0(0, 1);

    // stuck at 0
    mode = 1;
    start0();
    follow0(0, 0);

    // reset mid-run at vector 4
    mode = 0;
    start0();
    n = 0;
    while (DIN0 !== 3'd4 && n < 40) begin
      tick();
      n++;
    end
    check("reach_v4", DIN0, 4);
    #2 RST_N = 1'b0;
    #1 check_zero("abort");
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      START = i[0];
      tick();
      check("abort_done", DONE0, 0);
    end
    START = 1'b0;
    RST_N = 1'b1;
    tick();
    start0();
    follow0(0, 0);

    // START pulsed while busy is ignored
    start0();
    follow0(5, 1);

    // START held high: back-to-back runs
    mode = 1;
    START = 1'b1;
    sb.push_back(model(1, 2));
    tick();
    follow0(0, 0);
    mode = 0;
    sb.push_back(model(0, 2));
    tick();
    START = 1'b0;
    check("b2b_busy", BUSY0, 1);
    check("b2b_fcnt_clr", FC0, 0);
    check("b2b_din", DIN0, 0);
    follow0(0, 0);

    // SETTLE=1, stuck at 1
    START1 = 1'b1;
    sb.push_back(model(2, 1));
    tick();
    START1 = 1'b0;
    n = 1;
    while (DONE1 !== 1'b1 && n < 100) begin
      check("s1_din", DIN1, (n - 1) / 2);
      tick();
      n++;
    end
    e = sb.pop_front();
    check("s1_latency", n, e.lat);
    check("s1_pass", PASS1, e.pass);
    check("s1_fail_cnt", FC1, e.fcnt);
    check("s1_first_fail", FF1, e.ffail);
`ifdef TT_ERRMAP_EN
    check("s1_err_map", EM1, e.emap);
`endif
    tick();
    check("s1_done_pulse", DONE1, 0);
    check("s1_pass_hold", PASS1, e.pass);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
